// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the single-clock FIFO: pointer type, full/empty
// decode and the even-parity function used when SYNC_FIFO_PARITY_EN is defined.
package sync_fifo_pkg;

    localparam int PTR_W_MAX  = 17;
    localparam int DATA_W_MAX = 256;

    typedef logic [PTR_W_MAX-1:0] ptr_t;

    // Pointers arrive zero-extended; aw is the address width, bit aw is the wrap bit.
    // Returns {full, empty}.
    function automatic logic [1:0] ptr_status(input ptr_t wp, input ptr_t rp, input int unsigned aw);
        ptr_t amask;
        ptr_t diff;
        logic full;
        logic empty;
        amask = (ptr_t'(1) << aw) - ptr_t'(1);
        diff  = wp ^ rp;
        full  = ((diff & amask) == '0) && (((diff >> aw) & ptr_t'(1)) != '0);
        empty = (diff == '0);
        return {full, empty};
    endfunction

    function automatic logic even_parity(input logic [DATA_W_MAX-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// 1-write/1-read storage array; REG_READ selects a registered read port
// (data the cycle after re) or a combinational one.
module sync_fifo_mem #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 8,
    parameter bit REG_READ   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    if (REG_READ) begin : g_reg_read
        always_ff @(posedge clk) begin
            if (rst) begin
                rdata <= '0;
            end else if (re) begin
                rdata <= mem[raddr];
            end
        end
    end else begin : g_comb_read
        logic unused_in;
        assign unused_in = ^{re, rst};
        assign rdata     = mem[raddr];
    end

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller with thresholds, occupancy, sticky errors and FWFT mode.
// Optional macro SYNC_FIFO_PARITY_EN adds per-word even parity and the rerr output.
module sync_fifo_ctrl
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter bit FWFT       = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  winc,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  wfull,
    output logic                  walmost_full,
    input  logic                  rinc,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  rempty,
    output logic                  ralmost_empty,
    input  logic [ADDR_WIDTH:0]   afull_thresh,
    input  logic [ADDR_WIDTH:0]   aempty_thresh,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow,
    output logic                  underflow,
`ifdef SYNC_FIFO_PARITY_EN
    output logic                  rerr,
`endif
    input  logic                  clr_err
);

`ifdef SYNC_FIFO_PARITY_EN
    localparam int MEM_W = DATA_WIDTH + 1;
`else
    localparam int MEM_W = DATA_WIDTH;
`endif

    logic [ADDR_WIDTH:0] wptr, rptr;
    logic [ADDR_WIDTH:0] wptr_n, rptr_n, level_n;
    logic [ADDR_WIDTH:0] w_inc, r_inc;
    logic                w_acc, r_acc;
    logic [1:0]          st_n;
    logic [MEM_W-1:0]    mem_wdata, mem_rdata;

    // Acceptance uses the registered flags, so full/empty drop the conflicting side.
    assign w_acc   = winc & ~wfull;
    assign r_acc   = rinc & ~rempty;
    assign w_inc   = {{ADDR_WIDTH{1'b0}}, w_acc};
    assign r_inc   = {{ADDR_WIDTH{1'b0}}, r_acc};
    assign wptr_n  = wptr + w_inc;
    assign rptr_n  = rptr + r_inc;
    assign level_n = level + w_inc - r_inc;
    assign st_n    = ptr_status(ptr_t'(wptr_n), ptr_t'(rptr_n), ADDR_WIDTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr          <= '0;
            rptr          <= '0;
            level         <= '0;
            wfull         <= 1'b0;
            rempty        <= 1'b1;
            walmost_full  <= (afull_thresh == '0);
            ralmost_empty <= 1'b1;
            overflow      <= 1'b0;
            underflow     <= 1'b0;
        end else begin
            wptr          <= wptr_n;
            rptr          <= rptr_n;
            level         <= level_n;
            wfull         <= st_n[1];
            rempty        <= st_n[0];
            walmost_full  <= (level_n >= afull_thresh);
            ralmost_empty <= (level_n <= aempty_thresh);
            // A new error event in the same cycle as clr_err keeps the flag set.
            overflow      <= (winc & wfull) | (overflow & ~clr_err);
            underflow     <= (rinc & rempty) | (underflow & ~clr_err);
        end
    end

`ifdef SYNC_FIFO_PARITY_EN
    assign mem_wdata = {even_parity(DATA_W_MAX'(wdata)), wdata};
    assign rdata     = mem_rdata[DATA_WIDTH-1:0];
    assign rerr      = rvalid & (even_parity(DATA_W_MAX'(mem_rdata[DATA_WIDTH-1:0])) != mem_rdata[DATA_WIDTH]);
`else
    assign mem_wdata = wdata;
    assign rdata     = mem_rdata;
`endif

    sync_fifo_mem #(
        .WIDTH      (MEM_W),
        .ADDR_WIDTH (ADDR_WIDTH),
        .REG_READ   (!FWFT)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (w_acc),
        .waddr (wptr[ADDR_WIDTH-1:0]),
        .wdata (mem_wdata),
        .re    (r_acc),
        .raddr (rptr[ADDR_WIDTH-1:0]),
        .rdata (mem_rdata)
    );

    if (FWFT) begin : g_fwft
        assign rvalid = ~rempty;
    end else begin : g_regrd
        always_ff @(posedge clk) begin
            if (rst) begin
                rvalid <= 1'b0;
            end else begin
                rvalid <= r_acc;
            end
        end
    end

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
Parametrised single-clock FIFO. It is the synchronous successor to the team's async FIFO and uses the same winc/wdata/wfull and rinc/rdata/rempty handshake. Over the async version it adds:
- programmable almost-full and almost-empty thresholds
- an occupancy count
- sticky overflow/underflow error flags
- a selectable first-word-fall-through (FWFT) read mode

It sits between the bus-side producers and consumers inside one clock domain, and is the DUT for the next revision of the FIFO UVC.

Parameters:
- DATA_WIDTH, 32, width of each stored word.
- ADDR_WIDTH, 8, depth is 2**ADDR_WIDTH words.
- FWFT, 0, 0 = registered read (data one cycle after rinc); 1 = head word presented on rdata whenever rempty is low.

Ports:
- clk  in  1  the single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- winc  in  1  write request.
- wdata  in  DATA_WIDTH  write data.
- wfull  out  1  FIFO full; writes are rejected.
- walmost_full  out  1  level >= afull_thresh.
- rinc  in  1  read request / pop.
- rdata  out  DATA_WIDTH  read data.
- rvalid  out  1  FWFT=0: rdata valid this cycle; FWFT=1: equals ~rempty.
- rempty  out  1  FIFO empty.
- ralmost_empty  out  1  level <= aempty_thresh.
- afull_thresh  in  ADDR_WIDTH+1  almost-full threshold, quasi-static.
- aempty_thresh  in  ADDR_WIDTH+1  almost-empty threshold, quasi-static.
- level  out  ADDR_WIDTH+1  current occupancy, 0 to 2**ADDR_WIDTH.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.
- clr_err  in  1  clears overflow and underflow.

Interface fixed: one clock; reset is synchronous and active-high.

Behaviour:
- Reset (rst high at an edge):
  - wptr, rptr and level go to 0; rempty=1, wfull=0, rvalid=0, rdata=0.
  - overflow=0, underflow=0.
  - ralmost_empty = (0 <= aempty_thresh), i.e. 1.
  - walmost_full = (0 >= afull_thresh).
  - Array contents are not reset.
  - A reset mid-operation discards all stored data; the FIFO behaves as freshly empty on the next cycle.
- Pointers:
  - wptr and rptr are ADDR_WIDTH+1 bits, with the MSB as the wrap bit.
  - full = (address bits equal) and (MSBs differ); empty = (pointers equal).
  - Pointers wrap modulo 2**(ADDR_WIDTH+1).
- Acceptance, evaluated on current registered flags:
  - w_acc = winc & ~wfull.
  - r_acc = rinc & ~rempty.
  - When full, a simultaneous write+read accepts only the read. The write is dropped and overflow is set.
  - When empty, a simultaneous write+read accepts only the write. The read is dropped and underflow is set.
  - Otherwise both are accepted, and level is unchanged.
- Level:
  - level_next = level + w_acc - r_acc.
  - All flags are registered and computed from level_next, so they are accurate the cycle after the causing edge.
- Error flags:
  - overflow is set on winc & wfull; underflow is set on rinc & rempty.
  - clr_err clears both. If clear and set happen in the same cycle, set wins.
- FWFT=0 read: on r_acc, rdata <= mem[rptr] and rvalid <= 1, otherwise rvalid <= 0. rdata holds its last value.
- FWFT=1 read: rdata = mem[rptr[ADDR_WIDTH-1:0]] combinationally; rinc pops. The first write becomes visible the cycle after it is accepted.
- Thresholds outside 0..2**ADDR_WIDTH saturate the compare naturally; no error is raised.

Optional Feature:
SYNC_FIFO_PARITY_EN
- Defined:
  - Each word is stored with an extra even-parity bit computed from wdata.
  - On every read the parity is rechecked.
  - New output port rerr (1 bit) pulses with rvalid when parity mismatches.
  - rerr resets to 0.
- Undefined: no parity storage and no rerr port; array width is exactly DATA_WIDTH.

Decomposition:
- Package sync_fifo_pkg holds:
  - a ptr_t typedef parametrised via localparam defaults;
  - a function computing full/empty from two pointers;
  - the parity function.
- One natural sub-module, sync_fifo_mem: a 1-write/1-read storage array with a selectable registered or combinational read port. The controller instantiates it.

Test Plan:
- Reset, then ADDR_WIDTH=2, FWFT=0: write 0xA1,0xA2,0xA3,0xA4 -> wfull=1 and level=4 one cycle after the 4th write; reads return A1..A4 in order with rvalid; then rempty=1.
- Full with winc=1 and rinc=1 in the same cycle -> read accepted, level=3, overflow=1, wdata not stored.
- Empty, then assert rinc -> underflow=1, level stays 0. Next, clr_err for one cycle -> underflow=0. clr_err and a new underflow in the same cycle -> underflow stays 1.
- afull_thresh=3, aempty_thresh=1, depth 4: levels 0,1,2,3,4 -> ralmost_empty 1,1,0,0,0 and walmost_full 0,0,0,1,1.
- FWFT=1: write 0x55 -> next cycle rempty=0 and rdata=0x55 with no rinc; rinc -> rempty=1.
- Apply rst with level=3 -> next cycle level=0, rempty=1, error flags 0; after that, write 0x77 then read -> returns 0x77, with no stale data visible.
